pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Merges three hazard sources into one consistent set of per-stage enables, flush and bubble controls:
- load-use stall request from the hazard unit
- EX-stage taken-branch redirect
- data-memory ready handshake

Owns the multi-cycle branch-penalty flush sequence and a data-memory wait watchdog. Sits beside the hazard unit; drives the PC, IF/ID and ID/EX pipeline registers.

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline. It merges load-use,
//            taken-branch and data-memory wait into per-stage enables and
//            flush/bubble controls. Define PIPE_PERF_CNT_EN to build the
//            stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             clr_fault_i,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             fd_flush_o,
    output logic             ex_en_o,
    output logic             ex_bubble_o,
    output logic             dmem_abort_o,
    output logic             mem_fault_o,
    output logic             in_flush_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_cycles_o
);

    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_FLUSH     = 1'b1;
    localparam logic [3:0] C_PEN_RELOAD = 4'(BRANCH_PENALTY - 1);
    localparam logic [7:0] C_TIMEOUT    = 8'(MEM_TIMEOUT);

    logic [0:0] state_q, state_d;
    logic [3:0] pen_cnt_q, pen_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_fault_q, mem_fault_d;

    logic w_timeout;
    logic w_frozen;
    logic w_abort;

    assign w_timeout = (wait_cnt_q == C_TIMEOUT);
    assign w_frozen  = dmem_req_i & ~dmem_ready_i & ~w_timeout;
    assign w_abort   = dmem_req_i & ~dmem_ready_i &  w_timeout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pen_cnt_q   <= 4'd0;
            wait_cnt_q  <= 8'd0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pen_cnt_q   <= pen_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    // Next-state logic; a freeze holds the branch sequence exactly where it was
    always_comb begin
        state_d     = state_q;
        pen_cnt_d   = pen_cnt_q;
        wait_cnt_d  = 8'd0;
        mem_fault_d = mem_fault_q;

        if (w_abort) begin
            mem_fault_d = 1'b1;
        end else if (clr_fault_i) begin
            mem_fault_d = 1'b0;
        end

        if (w_frozen) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else if (branch_taken_i) begin
            if (BRANCH_PENALTY > 1) begin
                state_d   = ST_FLUSH;
                pen_cnt_d = C_PEN_RELOAD;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_FLUSH) begin
            pen_cnt_d = pen_cnt_q - 4'd1;
            if (pen_cnt_q == 4'd1) begin
                state_d = ST_RUN;
            end
        end
    end

    // Output logic
    always_comb begin
        pc_en_o      = 1'b0;
        fd_en_o      = 1'b0;
        fd_flush_o   = 1'b0;
        ex_en_o      = 1'b0;
        ex_bubble_o  = 1'b0;
        dmem_abort_o = 1'b0;

        if (rst_n && !w_frozen) begin
            dmem_abort_o = w_abort;
            if (branch_taken_i || (state_q == ST_FLUSH)) begin
                pc_en_o     = 1'b1;
                fd_en_o     = 1'b1;
                fd_flush_o  = 1'b1;
                ex_en_o     = 1'b1;
                ex_bubble_o = 1'b1;
            end else if (load_use_stall_i) begin
                ex_en_o     = 1'b1;
                ex_bubble_o = 1'b1;
            end else begin
                pc_en_o = 1'b1;
                fd_en_o = 1'b1;
                ex_en_o = 1'b1;
            end
        end
    end

    assign mem_fault_o = mem_fault_q;
    assign in_flush_o  = (state_q == ST_FLUSH);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters; they stay at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fd_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_cycles_o = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Scoreboard bench for pipeline_ctrl (BRANCH_PENALTY=2, MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    // Expected vector bits: pc_en fd_en fd_flush ex_en ex_bubble dmem_abort mem_fault in_flush
    localparam logic [7:0] E_ZERO = 8'b0000_0000;
    localparam logic [7:0] E_IDLE = 8'b1101_0000;
    localparam logic [7:0] E_LU   = 8'b0001_1000;
    localparam logic [7:0] E_FL   = 8'b1111_1000;
    localparam logic [7:0] B_INF  = 8'b0000_0001;
    localparam logic [7:0] B_MF   = 8'b0000_0010;
    localparam logic [7:0] B_AB   = 8'b0000_0100;

    typedef struct {
        logic [7:0] v;
        logic       rst;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lu = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic pc_en, fd_en, fd_flush, ex_en, ex_bubble, dmem_abort, mem_fault, in_flush;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    exp_t             sb[$];
    exp_t             cur;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .BRANCH_PENALTY(2),
        .MEM_TIMEOUT   (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_stall_i(lu),
        .branch_taken_i  (br),
        .dmem_req_i      (req),
        .dmem_ready_i    (rdy),
        .clr_fault_i     (clr),
        .pc_en_o         (pc_en),
        .fd_en_o         (fd_en),
        .fd_flush_o      (fd_flush),
        .ex_en_o         (ex_en),
        .ex_bubble_o     (ex_bubble),
        .dmem_abort_o    (dmem_abort),
        .mem_fault_o     (mem_fault),
        .in_flush_o      (in_flush),
        .stall_cycles_o  (stall_cycles),
        .flush_cycles_o  (flush_cycles)
    );

    // Drive one cycle of inputs just after the edge and queue its expected outputs
    task automatic cyc(input logic r, input logic l, input logic b, input logic q,
                       input logic d, input logic c, input logic [7:0] e, input string nm);
        exp_t item;
        @(posedge clk);
        #1;
        rst_n = r; lu = l; br = b; req = q; rdy = d; clr = c;
        item.v   = e;
        item.rst = ~r;
        item.nm  = nm;
        sb.push_back(item);
    endtask

    // Monitor: compare mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, fd_flush, ex_en, ex_bubble, dmem_abort, mem_fault, in_flush} !== cur.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", cur.nm,
                         {pc_en, fd_en, fd_flush, ex_en, ex_bubble, dmem_abort, mem_fault, in_flush}, cur.v);
            end
            if (cur.rst) begin
                m_stall = '0;
                m_flush = '0;
            end
            checks++;
            if (stall_cycles !== m_stall || flush_cycles !== m_flush) begin
                errors++;
                $display("FAIL %s_cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         cur.nm, stall_cycles, flush_cycles, m_stall, m_flush);
            end
`ifdef PIPE_PERF_CNT_EN
            if (!cur.rst) begin
                if (!cur.v[7]) m_stall = m_stall + 1;
                if (cur.v[5])  m_flush = m_flush + 1;
            end
`endif
        end
    end

    initial begin
        int guard;
        // Reset with hostile inputs present
        cyc(0, 1, 1, 1, 0, 1, E_ZERO, "reset_hold0");
        cyc(0, 1, 1, 1, 0, 1, E_ZERO, "reset_hold1");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE, "idle");
        // Single load-use
        cyc(1, 1, 0, 0, 0, 0, E_LU,   "load_use");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE, "after_lu");
        // Branch with penalty 2; load-use in the shadow is ignored
        cyc(1, 1, 1, 0, 0, 0, E_FL,         "branch_N");
        cyc(1, 1, 0, 0, 0, 0, E_FL | B_INF, "branch_N1");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE,       "branch_N2");
        // Three-cycle memory wait then release
        cyc(1, 1, 0, 1, 0, 0, E_ZERO, "memwait0");
        cyc(1, 0, 0, 1, 0, 0, E_ZERO, "memwait1");
        cyc(1, 0, 0, 1, 0, 0, E_ZERO, "memwait2");
        cyc(1, 0, 0, 1, 1, 0, E_IDLE, "mem_release");
        // Watchdog: wait counter must restart from zero
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0, E_ZERO, "wd_frozen");
        cyc(1, 0, 0, 1, 0, 0, E_IDLE | B_AB, "wd_abort");
        cyc(1, 0, 0, 0, 0, 1, E_IDLE | B_MF, "fault_set");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE,        "fault_clr");
        // Freeze during flush with pen_cnt=1
        cyc(1, 0, 1, 0, 0, 0, E_FL,          "fz_branch");
        cyc(1, 0, 0, 1, 0, 0, E_ZERO | B_INF, "fz_hold0");
        cyc(1, 0, 0, 1, 0, 0, E_ZERO | B_INF, "fz_hold1");
        cyc(1, 0, 0, 0, 0, 0, E_FL | B_INF,  "fz_release");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE,        "fz_run");
        // Branch in FLUSH restarts the penalty
        cyc(1, 0, 1, 0, 0, 0, E_FL,         "rs_branch0");
        cyc(1, 0, 1, 0, 0, 0, E_FL | B_INF, "rs_branch1");
        cyc(1, 0, 0, 0, 0, 0, E_FL | B_INF, "rs_flush");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE,       "rs_run");
        // Abort coincident with branch and clr_fault: set wins, branch proceeds
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0, E_ZERO, "wd2_frozen");
        cyc(1, 0, 1, 1, 0, 1, E_FL | B_AB,          "wd2_abort_br");
        cyc(1, 0, 0, 0, 0, 0, E_FL | B_MF | B_INF,  "wd2_flush");
        cyc(1, 0, 0, 0, 0, 1, E_IDLE | B_MF,        "wd2_clr");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE,               "wd2_cleared");
        // Reset mid-flush
        cyc(1, 0, 1, 0, 0, 0, E_FL,   "rm_branch");
        cyc(0, 0, 0, 0, 0, 0, E_ZERO, "rm_reset");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE, "rm_idle0");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE, "rm_idle1");

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
